div_clock_tick_sync: RTL

- Receiving end of the divided clock produced by the ripple divider.
- Samples the slow, asynchronous `div_clock` in the fast `clock` domain and synchronises it.
- Emits single-cycle rise/fall enable ticks, so downstream logic runs on `clock` with enables rather than on a derived clock.
- Measures the divided period and flags lock/timeout for the health of the divider chain.

---
 rtl/div_clock_tick_sync_if.sv | 28 ++
 rtl/div_clock_tick_sync.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_clock_tick_sync_if.sv
// Purpose : carries the divided clock in, and the tick/period/health results out, of div_clock_tick_sync.
// Latency : n/a (wires only).
// Backpressure: none; every signal is a level or a single-cycle pulse with no ready.
// Ports   : div_clock_in (async divided clock), level, tick_rise, tick_fall,
//           period[PERIOD_WIDTH], period_valid, locked, timeout.
//           master = the sync block (drives results), slave = the consumer.
interface div_clock_tick_sync_if #(
   parameter int PERIOD_WIDTH = 24
);
   logic                    div_clock_in;
   logic                    level;
   logic                    tick_rise;
   logic                    tick_fall;
   logic [PERIOD_WIDTH-1:0] period;
   logic                    period_valid;
   logic                    locked;
   logic                    timeout;

   modport master (
      input  div_clock_in,
      output level, tick_rise, tick_fall, period, period_valid, locked, timeout
   );

   modport slave (
      output div_clock_in,
      input  level, tick_rise, tick_fall, period, period_valid, locked, timeout
   );
endinterface

// File: rtl/div_clock_tick_sync.sv
// Purpose : synchronise the slow divided clock into `clock`, emit rise/fall enable ticks, measure period, flag lock/timeout.
// Latency : level/ticks one cycle after edge k+SYNC_STAGES (input first sampled high at edge k), +3 with the filter; period/locked one cycle after tick_rise.
// Backpressure: none; ticks and timeout are fire-and-forget single-cycle pulses.
// Ports   : clock, reset (sync, active-high), bus (div_clock_tick_sync_if.master).
// Option  : define DIV_CLOCK_TICK_SYNC_GLITCH_FILTER_EN to insert a 3-cycle stability
//           filter after the synchroniser (rejects pulses shorter than 3 cycles).
module div_clock_tick_sync #(
   parameter int SYNC_STAGES    = 2,
   parameter int PERIOD_WIDTH   = 24,
   parameter int EXPECT_PERIOD  = 131072,
   parameter int TOLERANCE      = 4,
   parameter int TIMEOUT_CYCLES = 262144
) (
   input  logic                 clock,
   input  logic                 reset,
   div_clock_tick_sync_if.master bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] TRACK = 2'd2;

   localparam logic [PERIOD_WIDTH-1:0] TMO_VAL = PERIOD_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [PERIOD_WIDTH-1:0] EXP_VAL = PERIOD_WIDTH'(EXPECT_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] TOL_VAL = PERIOD_WIDTH'(TOLERANCE);
   localparam logic [PERIOD_WIDTH-1:0] ONE     = PERIOD_WIDTH'(1);

   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    s;
   logic                    f;
   logic                    prev_q;
   logic                    level_q;
   logic                    tick_rise_q;
   logic                    tick_fall_q;
   logic [PERIOD_WIDTH-1:0] cnt_q;
   logic [PERIOD_WIDTH-1:0] period_q;
   logic                    period_valid_q;
   logic                    locked_q;
   logic                    timeout_q;
   logic [1:0]              state_q;
   logic                    good_q;   // previous measurement was in tolerance
   logic [PERIOD_WIDTH-1:0] dev;
   logic                    in_tol;
   logic                    tmo_hit;

   // Synchroniser: new sample enters at bit 0, settled value leaves at the top.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.div_clock_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef DIV_CLOCK_TICK_SYNC_GLITCH_FILTER_EN
   logic       filt_q;
   logic [1:0] stab_q;

   // The filtered value follows s only once s has disagreed with it for 3 cycles in a row.
   always_ff @(posedge clock) begin
      if (reset) begin
         filt_q <= 1'b0;
         stab_q <= 2'd0;
      end else if (s == filt_q) begin
         stab_q <= 2'd0;
      end else if (stab_q == 2'd2) begin
         filt_q <= s;
         stab_q <= 2'd0;
      end else begin
         stab_q <= stab_q + 2'd1;
      end
   end

   assign f = filt_q;
`else
   assign f = s;
`endif

   // Edge detection, all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q      <= 1'b0;
         level_q     <= 1'b0;
         tick_rise_q <= 1'b0;
         tick_fall_q <= 1'b0;
      end else begin
         prev_q      <= f;
         level_q     <= f;
         tick_rise_q <= f & ~prev_q;
         tick_fall_q <= ~f & prev_q;
      end
   end

   // Absolute deviation from nominal, computed without wrap.
   assign dev     = (cnt_q >= EXP_VAL) ? (cnt_q - EXP_VAL) : (EXP_VAL - cnt_q);
   assign in_tol  = (dev <= TOL_VAL);
   // A rise in the same cycle as saturation wins over the timeout.
   assign tmo_hit = (state_q != IDLE) && !tick_rise_q && (cnt_q == TMO_VAL);

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         timeout_q      <= 1'b0;
         state_q        <= IDLE;
         good_q         <= 1'b0;
      end else begin
         timeout_q <= 1'b0;

         // cnt equals the rise-to-rise distance on the cycle tick_rise is high.
         if (tick_rise_q) begin
            cnt_q <= ONE;
         end else if (cnt_q != TMO_VAL) begin
            cnt_q <= cnt_q + ONE;
         end

         if (tmo_hit) begin
            timeout_q      <= 1'b1;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            good_q         <= 1'b0;
            state_q        <= IDLE;
         end else if (tick_rise_q) begin
            case (state_q)
               IDLE: begin
                  state_q <= ARMED;
               end
               ARMED: begin
                  period_q       <= cnt_q;
                  period_valid_q <= 1'b1;
                  good_q         <= in_tol;
                  state_q        <= TRACK;
               end
               TRACK: begin
                  period_q <= cnt_q;
                  if (in_tol) begin
                     locked_q <= good_q;
                     good_q   <= 1'b1;
                  end else begin
                     locked_q <= 1'b0;
                     good_q   <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.level        = level_q;
   assign bus.tick_rise    = tick_rise_q;
   assign bus.tick_fall    = tick_fall_q;
   assign bus.period       = period_q;
   assign bus.period_valid = period_valid_q;
   assign bus.locked       = locked_q;
   assign bus.timeout      = timeout_q;

endmodule
